// File: rtl/ternary_pkg.sv
// Shared state type, constants and helpers for external register-port targets.
package ternary_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4,
        DRAIN = 3'd5
    } ext_resp_state_t;

    localparam logic [31:0] EXT_ERR_RDATA = 32'hDEAD_BEEF;
    localparam logic [31:0] TPU_BASE      = 32'h0000_1000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ext_reg_responder_if.sv
// External register port as seen between a host initiator (master) and a target (slave).
interface ext_reg_responder_if;
    logic        sel;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output sel, wen, ren, addr, wdata, input rdata, ready);
    modport slave  (input sel, wen, ren, addr, wdata, output rdata, ready);
endinterface

// File: rtl/ext_addr_window_dec.sv
// Combinational window/alignment decoder: hit when a word-aligned address falls
// inside [BASE_ADDR, BASE_ADDR+WINDOW_BYTES); also returns the word offset.
module ext_addr_window_dec
    import ternary_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = TPU_BASE,
    parameter int          WINDOW_BYTES = 256,
    localparam int         OFF_W        = $clog2(WINDOW_BYTES) - 2
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [OFF_W-1:0] word_off
);
    logic [29:0] rel_words;

    // Window is a power of two, so "below the top" reduces to zero upper offset bits.
    always_comb begin
        rel_words = addr[31:2] - BASE_ADDR[31:2];
        hit       = (addr >= BASE_ADDR) && (rel_words[29:OFF_W] == '0) && (addr[1:0] == 2'b00);
        word_off  = rel_words[OFF_W-1:0];
    end
endmodule

// File: rtl/ext_reg_responder.sv
// Responder for the external register port: one req/ack transaction per access, bounded
// error completions. Define EXT_REG_RESPONDER_STATS_EN to add rd_count/wr_count outputs.
module ext_reg_responder
    import ternary_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = TPU_BASE,
    parameter int          WINDOW_BYTES = 256,
    parameter int          TIMEOUT_CYC  = 64,
    parameter logic [31:0] ERR_RDATA    = EXT_ERR_RDATA,
    localparam int         OFF_W        = $clog2(WINDOW_BYTES) - 2
) (
    input  logic                clk,
    input  logic                rst,
    ext_reg_responder_if.slave  ext,
    output logic                reg_req,
    output logic                reg_we,
    output logic [OFF_W-1:0]    reg_addr,
    output logic [31:0]         reg_wdata,
    input  logic                reg_ack,
    input  logic [31:0]         reg_rdata,
`ifdef EXT_REG_RESPONDER_STATS_EN
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count,
`endif
    output logic                err_sticky,
    output logic [7:0]          err_count
);
    localparam int              TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    ext_resp_state_t  state_q, state_d;
    logic             ext_ready_q, ext_ready_d;
    logic [31:0]      ext_rdata_q, ext_rdata_d;
    logic             reg_req_q, reg_req_d;
    logic             reg_we_q, reg_we_d;
    logic [OFF_W-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]      reg_wdata_q, reg_wdata_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;
    logic             err_fire;
    logic             dec_hit;
    logic [OFF_W-1:0] dec_off;
    logic             acc_ok;
`ifdef EXT_REG_RESPONDER_STATS_EN
    logic [15:0]      rd_cnt_q, rd_cnt_d;
    logic [15:0]      wr_cnt_q, wr_cnt_d;
`endif

    ext_addr_window_dec #(
        .BASE_ADDR    (BASE_ADDR),
        .WINDOW_BYTES (WINDOW_BYTES)
    ) u_dec (
        .addr     (ext.addr),
        .hit      (dec_hit),
        .word_off (dec_off)
    );

    assign acc_ok = (ext.wen ^ ext.ren) & dec_hit;

    always_comb begin
        state_d      = state_q;
        ext_ready_d  = 1'b0;
        ext_rdata_d  = ext_rdata_q;
        reg_req_d    = reg_req_q;
        reg_we_d     = reg_we_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        tmo_d        = tmo_q;
        err_fire     = 1'b0;
`ifdef EXT_REG_RESPONDER_STATS_EN
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // The only point where ext_* inputs are captured for this access.
                if (ext.sel) begin
                    reg_we_d    = ext.wen;
                    reg_addr_d  = dec_off;
                    reg_wdata_d = ext.wdata;
                    if (acc_ok) begin
                        state_d   = ISSUE;
                        reg_req_d = 1'b1;
                    end else begin
                        state_d     = ERR;
                        ext_ready_d = 1'b1;
                        ext_rdata_d = ext.wen ? 32'd0 : ERR_RDATA;
                        err_fire    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (reg_ack) begin
                    state_d     = RESP;
                    reg_req_d   = 1'b0;
                    ext_ready_d = 1'b1;
                    ext_rdata_d = reg_we_q ? 32'd0 : reg_rdata;
`ifdef EXT_REG_RESPONDER_STATS_EN
                    if (reg_we_q) begin
                        wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
                    end else begin
                        rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
                    end
`endif
                end else if (tmo_q == TO_LAST) begin
                    state_d     = ERR;
                    reg_req_d   = 1'b0;
                    ext_ready_d = 1'b1;
                    ext_rdata_d = reg_we_q ? 32'd0 : ERR_RDATA;
                    err_fire    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP, ERR: state_d = DRAIN;
            DRAIN: begin
                // Hold off until the initiator releases sel so a held request is not reissued.
                if (!ext.sel) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (err_fire) begin
            err_sticky_d = 1'b1;
            err_count_d  = sat_inc8(err_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ext_ready_q  <= 1'b0;
            ext_rdata_q  <= '0;
            reg_req_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            tmo_q        <= '0;
`ifdef EXT_REG_RESPONDER_STATS_EN
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ext_ready_q  <= ext_ready_d;
            ext_rdata_q  <= ext_rdata_d;
            reg_req_q    <= reg_req_d;
            reg_we_q     <= reg_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            tmo_q        <= tmo_d;
`ifdef EXT_REG_RESPONDER_STATS_EN
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
`endif
        end
    end

    assign ext.ready  = ext_ready_q;
    assign ext.rdata  = ext_rdata_q;
    assign reg_req    = reg_req_q;
    assign reg_we     = reg_we_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
`ifdef EXT_REG_RESPONDER_STATS_EN
    assign rd_count   = rd_cnt_q;
    assign wr_count   = wr_cnt_q;
`endif

endmodule

// File: tb/tb_ext_reg_responder.sv
// Self-checking bench for ext_reg_responder: directed vector table, randomized accesses
// against a rule-level reference model, and a mid-transaction reset sequence.
module tb_ext_reg_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          WIN  = 256;
    localparam int          TMO  = 64;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_req, reg_we, reg_ack;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        err_sticky;
    logic [7:0]  err_count;
`ifdef EXT_REG_RESPONDER_STATS_EN
    logic [15:0] rd_count, wr_count;
`endif

    ext_reg_responder_if bus();

    ext_reg_responder #(
        .BASE_ADDR    (BASE),
        .WINDOW_BYTES (WIN),
        .TIMEOUT_CYC  (TMO),
        .ERR_RDATA    (ERRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ext        (bus),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_ack    (reg_ack),
        .reg_rdata  (reg_rdata),
`ifdef EXT_REG_RESPONDER_STATS_EN
        .rd_count   (rd_count),
        .wr_count   (wr_count),
`endif
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // delay: reg_ack is raised when reg_req has been high for delay+1 cycles; -1 = never
    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        int          delay;
        int          hold;
        int          exp_ready_cyc;
        bit          exp_req;
        bit          chk_rdata;
        logic [31:0] exp_rdata;
        logic [5:0]  exp_off;
        bit          exp_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int m_err  = 0;
    int m_rd   = 0;
    int m_wr   = 0;
    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic ren, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdin, input int delay,
                                input int hold, input int rcyc, input bit req, input bit chk,
                                input logic [31:0] rd, input logic [5:0] off, input bit err);
        vec_t v;
        v.wen = wen; v.ren = ren; v.addr = addr; v.wdata = wdata; v.rdata_in = rdin;
        v.delay = delay; v.hold = hold; v.exp_ready_cyc = rcyc; v.exp_req = req;
        v.chk_rdata = chk; v.exp_rdata = rd; v.exp_off = off; v.exp_err = err;
        return v;
    endfunction

    // Reference: derive the expected completion directly from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit strobe_ok, in_win, acked;
        r         = v;
        strobe_ok = (v.wen != v.ren);
        in_win    = (v.addr >= BASE) && (v.addr < BASE + WIN) && (v.addr % 4 == 0);
        acked     = (v.delay >= 1) && (v.delay <= TMO);
        r.exp_off = 6'((v.addr - BASE) / 4);
        if (!(strobe_ok && in_win)) begin
            r.exp_ready_cyc = 1;
            r.exp_req       = 0;
            r.exp_err       = 1;
            r.chk_rdata     = strobe_ok;
            r.exp_rdata     = v.wen ? 32'd0 : ERRD;
        end else begin
            r.exp_req       = 1;
            r.chk_rdata     = 1;
            r.exp_err       = !acked;
            r.exp_ready_cyc = acked ? v.delay + 2 : TMO + 2;
            r.exp_rdata     = v.wen ? 32'd0 : (acked ? v.rdata_in : ERRD);
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int          k, ready_cnt, ready_cyc, req_rises, req_hi, sel_low;
        logic [31:0] ready_data, got_wd;
        logic        req_prev, got_we;
        logic [5:0]  got_off;
        k = 0; ready_cnt = 0; ready_cyc = 0; req_rises = 0; req_hi = 0; sel_low = 0;
        ready_data = '0; got_wd = '0; got_we = 1'b0; got_off = '0; req_prev = 1'b0;
        bus.sel = 1'b1; bus.wen = v.wen; bus.ren = v.ren; bus.addr = v.addr; bus.wdata = v.wdata;
        reg_rdata = v.rdata_in;
        reg_ack   = 1'($urandom_range(0, 1));
        while (sel_low < 3 && k < TMO + 40) begin
            @(negedge clk);
            k++;
            if (bus.ready) begin
                ready_cnt++;
                if (ready_cnt == 1) begin
                    ready_cyc  = k;
                    ready_data = bus.rdata;
                end
            end
            if (reg_req && !req_prev) begin
                req_rises++;
                got_we = reg_we; got_off = reg_addr; got_wd = reg_wdata;
            end
            req_prev = reg_req;
            req_hi   = reg_req ? req_hi + 1 : 0;
            // Spurious acks while no request is outstanding must be ignored.
            if (reg_req) reg_ack = (v.delay >= 0) && (req_hi == v.delay + 1);
            else         reg_ack = 1'($urandom_range(0, 1));
            if (!bus.sel) begin
                sel_low++;
            end else begin
                bus.wen   = 1'($urandom_range(0, 1));
                bus.ren   = 1'($urandom_range(0, 1));
                bus.addr  = $urandom;
                bus.wdata = $urandom;
                if (ready_cnt > 0 && k >= ready_cyc + v.hold) bus.sel = 1'b0;
            end
        end
        reg_ack = 1'b0;
        bus.sel = 1'b0;
        if (ready_cnt == 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: got no ext_ready in %0d cycles, expected one at cycle %0d",
                     tag, k, v.exp_ready_cyc);
        end else begin
            check({tag, " ready_cycle"}, ready_cyc, v.exp_ready_cyc);
            if (v.chk_rdata) check({tag, " rdata"}, ready_data, v.exp_rdata);
        end
        check({tag, " ready_pulses"}, ready_cnt, 1);
        check({tag, " req_count"}, req_rises, v.exp_req ? 1 : 0);
        if (v.exp_req && req_rises > 0) begin
            check({tag, " reg_we"}, got_we, v.wen);
            check({tag, " reg_addr"}, got_off, v.exp_off);
            check({tag, " reg_wdata"}, got_wd, v.wdata);
        end
        if (v.exp_err) m_err = (m_err == 255) ? 255 : m_err + 1;
        else if (v.wen) m_wr++;
        else m_rd++;
        check({tag, " err_count"}, err_count, m_err);
        check({tag, " err_sticky"}, err_sticky, (m_err != 0));
`ifdef EXT_REG_RESPONDER_STATS_EN
        check({tag, " wr_count"}, wr_count, m_wr);
        check({tag, " rd_count"}, rd_count, m_rd);
`endif
        $display("txn %s addr=0x%08h wen=%0b ren=%0b delay=%0d ready@%0d rdata=0x%08h",
                 tag, v.addr, v.wen, v.ren, v.delay, ready_cyc, ready_data);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ext_ready"}, bus.ready, 0);
        check({tag, " ext_rdata"}, bus.rdata, 0);
        check({tag, " reg_req"}, reg_req, 0);
        check({tag, " reg_we"}, reg_we, 0);
        check({tag, " reg_addr"}, reg_addr, 0);
        check({tag, " reg_wdata"}, reg_wdata, 0);
        check({tag, " err_sticky"}, err_sticky, 0);
        check({tag, " err_count"}, err_count, 0);
`ifdef EXT_REG_RESPONDER_STATS_EN
        check({tag, " rd_count"}, rd_count, 0);
        check({tag, " wr_count"}, wr_count, 0);
`endif
    endtask

    initial begin
        int   kind, spur;
        vec_t v;
        rst = 1'b1; reg_ack = 1'b0; reg_rdata = '0;
        bus.sel = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        //          wen ren addr          wdata         rdata_in      dly hld rdy req chk exp_rdata     off    err
        tbl[0]  = mk(1, 0, 32'h0000_1008, 32'h0000_1000, 32'h1234_5678,  1, 0,  3, 1, 1, 32'h0,        6'h02, 0);
        tbl[1]  = mk(0, 1, 32'h0000_1018, 32'h0,         32'h0002_0820,  5, 1,  7, 1, 1, 32'h0002_0820,6'h06, 0);
        tbl[2]  = mk(0, 1, 32'h0000_2000, 32'h0,         32'h0,          1, 0,  1, 0, 1, ERRD,         6'h00, 1);
        tbl[3]  = mk(0, 1, 32'h0000_1044, 32'h0,         32'h0,         -1, 0, 66, 1, 1, ERRD,         6'h11, 1);
        tbl[4]  = mk(1, 1, 32'h0000_1000, 32'h0,         32'h0,          1, 0,  1, 0, 0, 32'h0,        6'h00, 1);
        tbl[5]  = mk(0, 1, 32'h0000_1002, 32'h0,         32'h0,          1, 0,  1, 0, 1, ERRD,         6'h00, 1);
        tbl[6]  = mk(0, 1, 32'h0000_10FC, 32'h0,         32'hCAFE_0001, 64, 2, 66, 1, 1, 32'hCAFE_0001,6'h3F, 0);
        tbl[7]  = mk(1, 0, 32'h0000_1100, 32'h5,         32'h0,          1, 0,  1, 0, 1, 32'h0,        6'h00, 1);
        tbl[8]  = mk(0, 1, 32'h0000_0FFC, 32'h0,         32'h0,          1, 0,  1, 0, 1, ERRD,         6'h00, 1);
        tbl[9]  = mk(0, 1, 32'h0000_1000, 32'h0,         32'h1111,       0, 0, 66, 1, 1, ERRD,         6'h00, 1);
        tbl[10] = mk(1, 0, 32'h0000_1004, 32'hABCD,      32'h0,         65, 0, 66, 1, 1, 32'h0,        6'h01, 1);
        tbl[11] = mk(0, 0, 32'h0000_1010, 32'h0,         32'h0,          1, 3,  1, 0, 0, 32'h0,        6'h00, 1);
        tbl[12] = mk(1, 0, 32'h0000_1020, 32'h77,        32'h0,          2, 0,  4, 1, 1, 32'h0,        6'h08, 0);
        tbl[13] = mk(1, 0, 32'h0000_1030, 32'h88,        32'h0,          3, 0,  5, 1, 1, 32'h0,        6'h0C, 0);
        tbl[14] = mk(0, 1, 32'h0000_1080, 32'h0,         32'h0BAD_F00D, 10, 0, 12, 1, 1, 32'h0BAD_F00D,6'h20, 0);
        for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("dir%0d", i));

        for (int i = 0; i < 40; i++) begin
            kind    = $urandom_range(0, 9);
            v.wen   = 1'($urandom_range(0, 1));
            v.ren   = (kind == 0) ? v.wen : ~v.wen;
            v.addr  = BASE + 32'($urandom_range(0, 63)) * 4;
            if (kind == 1) v.addr = $urandom;
            if (kind == 2) v.addr = v.addr + 32'($urandom_range(1, 3));
            v.wdata    = $urandom;
            v.rdata_in = $urandom;
            v.delay    = (kind == 3) ? -1 : (kind == 4) ? $urandom_range(60, 70) : $urandom_range(0, 8);
            v.hold     = $urandom_range(0, 3);
            run_vec(model(v), $sformatf("rnd%0d", i));
        end

        // Reset asserted while a read is parked in WAIT.
        bus.sel = 1'b1; bus.wen = 1'b0; bus.ren = 1'b1; bus.addr = 32'h0000_1010; reg_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst req_before", reg_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0; bus.sel = 1'b0;
        m_err = 0; m_rd = 0; m_wr = 0;
        spur = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ready || reg_req) spur++;
        end
        check("midrst no_activity", spur, 0);
        run_vec(tbl[0], "post_rst");
        run_vec(tbl[2], "post_rst_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_reg_responder.md
Name: ext_reg_responder

Overview:
- Target (responder) end of the SoC external register port (ext_sel/ext_wen/ext_ren/ext_addr/ext_wdata -> ext_rdata/ext_ready) that host-side initiators drive.
- Decodes the TPU register window and forwards each access as a single request/ack transaction to the internal register block. Returns read data and ready to the initiator.
- Converts out-of-window accesses and target stalls into bounded, flagged error responses so the initiator never hangs.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte base of the decoded window
- WINDOW_BYTES, 256, window size in bytes; power of two
- TIMEOUT_CYC, 64, max cycles waiting for reg_ack before error completion; >= 2
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on any error completion

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ext_sel  in  1  access select from initiator
- ext_wen  in  1  write strobe
- ext_ren  in  1  read strobe
- ext_addr  in  32  byte address
- ext_wdata  in  32  write data
- ext_rdata  out  32  read data; valid only while ext_ready=1
- ext_ready  out  1  one-cycle completion pulse
- reg_req  out  1  request to register block; held until reg_ack or timeout
- reg_we  out  1  1=write, 0=read
- reg_addr  out  $clog2(WINDOW_BYTES)-2  word offset within window
- reg_wdata  out  32  write data
- reg_ack  in  1  register block completion
- reg_rdata  in  32  read data; valid with reg_ack
- err_sticky  out  1  set on any error completion; cleared only by rst
- err_count  out  8  saturating count of error completions

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; ext_ready=0, ext_rdata=0, reg_req=0, reg_we=0, reg_addr=0, reg_wdata=0, err_sticky=0, err_count=0, timeout counter=0.
- Access = ext_sel & (ext_wen ^ ext_ren). If ext_sel=1 with both strobes set or both clear: error completion, no reg_req.
- In-window test: BASE_ADDR <= ext_addr < BASE_ADDR+WINDOW_BYTES, and ext_addr[1:0]==0. Any failure -> error completion.
- Inputs are sampled once, at the IDLE->next transition, into registers. Later changes on the ext_* inputs are ignored until DRAIN exits.
- FSM states:
  - IDLE: on valid in-window access -> ISSUE. On invalid access -> ERR.
  - ISSUE: reg_req=1 with captured we/addr/wdata; timeout counter cleared -> WAIT. reg_req stays high through WAIT.
  - WAIT: if reg_ack=1 -> RESP, capturing reg_rdata (writes return 0). Else if counter == TIMEOUT_CYC-1 -> ERR. Else counter++.
  - RESP: ext_ready=1 for exactly one cycle; ext_rdata = captured data; reg_req=0 -> DRAIN.
  - ERR: ext_ready=1 for one cycle; ext_rdata = ERR_RDATA for reads, 0 for writes; reg_req=0; err_sticky<=1; err_count++ saturating at 255 -> DRAIN.
  - DRAIN: wait for ext_sel=0, then -> IDLE. This prevents a held request from being reissued after ready.
- Minimum latency, in-window access with reg_ack in the first WAIT cycle: sel sampled at cycle 0, ext_ready at cycle 3.
- reg_ack arriving outside WAIT is ignored. reg_ack in the same cycle the timeout expires counts as success (ack has priority).
- ext_rdata holds its last value when ext_ready=0. Verification checks it only under ready.
- Mid-transaction reset: everything returns to reset values next cycle; no ext_ready pulse; reg_req drops immediately.
- Back-to-back accesses: at least one cycle with ext_sel=0 between them (DRAIN enforces this).

Optional Feature:
- Macro: EXT_REG_RESPONDER_STATS_EN.
- Defined: adds outputs rd_count[15:0] and wr_count[15:0]. Each increments on successful RESP of a read or write respectively, saturating at 16'hFFFF, reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package ternary_pkg:
  - state enum ext_resp_state_t {IDLE, ISSUE, WAIT, RESP, ERR, DRAIN}
  - EXT_ERR_RDATA default constant
  - TPU_BASE constant
- Sub-module ext_addr_window_dec: combinational in-window and alignment check returning hit and word offset, so other bus targets can reuse it.
- FSM and counters remain in the top module.

Test Plan:
- Write 0x1008 = 0x0000_1000 with reg_ack one cycle after reg_req -> reg_we=1, reg_addr=2, reg_wdata=0x1000, one ext_ready pulse at cycle 3, err_sticky=0.
- Read 0x1018 with reg_rdata=0x0002_0820, ack after 5 cycles -> ext_rdata=0x0002_0820 under ext_ready, one pulse only; initiator holds sel one extra cycle -> no second reg_req.
- Read 0x2000 (out of window) -> no reg_req, ext_ready at cycle 1 after IDLE, ext_rdata=0xDEAD_BEEF, err_sticky=1, err_count=1.
- Read 0x1044 with reg_ack never asserted -> ext_ready after 64 WAIT cycles with 0xDEAD_BEEF, reg_req drops, err_count increments.
- ext_sel with wen=ren=1, then misaligned 0x1002 -> both error completions, err_count=2; assert rst during a WAIT -> all outputs zero next cycle, no ext_ready.
- With EXT_REG_RESPONDER_STATS_EN: 3 successful writes, 2 successful reads, 1 error -> wr_count=3, rd_count=2.
